// File: rtl/imem_prog.sv
// ---------------------------------------------------------------------------
// imem_prog : loadable instruction memory
//
// Holds 2**AW words of IW-bit machine code. A program is streamed in over a
// valid/ready loader port after a load_start pulse. In RUN the CPU fetches by
// PC with a registered one-cycle read latency. Entries not written since the
// last load began read back as HALT_WORD, so a short program always stops.
//
// Ports:
//   CLK         clock, rising edge
//   reset_n     asynchronous active-low reset
//   load_start  pulse: begin (or restart) a program load
//   ld_valid    loader word valid
//   ld_data     loader instruction word
//   ld_last     final word of the program (qualified by ld_valid)
//   ld_ready    block accepts a loader word this cycle
//   load_done   level: a load completed, block is in RUN
//   load_err    sticky: load filled every entry without seeing ld_last
//   load_count  words accepted in the current/last load
//   fetch_en    fetch request for address PC
//   PC          fetch address
//   inst        fetched instruction (registered)
//   inst_valid  inst was updated by a fetch in the previous cycle
// ---------------------------------------------------------------------------
module imem_prog #(
    parameter int              IW        = 9,
    parameter int              AW        = 8,
    parameter logic [IW-1:0]   HALT_WORD = {IW{1'b1}}
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   load_count,
    input  logic          fetch_en,
    input  logic [AW-1:0] PC,
    output logic [IW-1:0] inst,
    output logic          inst_valid
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic [AW-1:0]     ptr_q,        ptr_d;
    logic [AW:0]       count_q,      count_d;
    logic [DEPTH-1:0]  valid_q,      valid_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;
    logic [IW-1:0]     inst_q,       inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              we_s;

    logic [IW-1:0]     mem_q [DEPTH];

    // Next-state and next-output computation for the loader/fetch controller.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        valid_d      = valid_q;
        done_d       = done_q;
        err_d        = err_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        we_s         = 1'b0;

        // load_start wins in every state: a restart discards any beat or
        // fetch presented in the same cycle.
        if (load_start) begin
            state_d = LOAD;
            ptr_d   = {AW{1'b0}};
            count_d = {(AW+1){1'b0}};
            valid_d = {DEPTH{1'b0}};
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LOAD: begin
                    if (ld_valid) begin
                        we_s           = 1'b1;
                        valid_d[ptr_q] = 1'b1;
                        ptr_d          = ptr_q + AW'(1);
                        if (count_q == (AW+1)'(DEPTH)) begin
                            count_d = count_q;
                        end else begin
                            count_d = count_q + (AW+1)'(1);
                        end
                        if (ld_last) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else if (&ptr_q) begin
                            // Last entry filled with no end marker: overflow.
                            state_d = RUN;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                RUN: begin
                    if (fetch_en) begin
                        inst_d       = valid_q[PC] ? mem_q[PC] : HALT_WORD;
                        inst_valid_d = 1'b1;
                    end else begin
                        inst_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Controller state, valid bits and registered outputs.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= {AW{1'b0}};
            count_q      <= {(AW+1){1'b0}};
            valid_q      <= {DEPTH{1'b0}};
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            inst_q       <= HALT_WORD;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Program storage; contents are masked by valid_q so no reset is needed.
    always_ff @(posedge CLK) begin
        if (we_s) begin
            mem_q[ptr_q] <= ld_data;
        end
    end

    assign ld_ready   = (state_q == LOAD);
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign load_count = count_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: doc/imem_prog.md
Name: imem_prog

Overview:
- Parametrised, loadable successor to the fixed case-statement instruction ROM.
- Holds DEPTH = 2**AW words of IW-bit machine code in a register array.
- Program is streamed in over a valid/ready loader port, then fetched by the PC with registered, 1-cycle read latency.
- Unprogrammed entries read back as HALT_WORD, so a short program always terminates. Sits between the testbench/boot loader and the CPU fetch stage.

Parameters:
- IW, 9, instruction width in bits
- AW, 8, PC/address width; DEPTH = 2**AW entries
- HALT_WORD, {IW{1'b1}}, word returned for any entry not written since the last load began

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse: begin a new program load
- ld_valid  in  1  loader word valid
- ld_data  in  IW  loader instruction word
- ld_last  in  1  marks the final word of the program (qualified by ld_valid)
- ld_ready  out  1  block accepts a loader word this cycle
- load_done  out  1  level: a load has completed and the block is in RUN
- load_err  out  1  sticky: program overflowed DEPTH without ld_last
- load_count  out  AW+1  number of words accepted in the current/last load
- fetch_en  in  1  fetch request for address PC
- PC  in  AW  fetch address
- inst  out  IW  fetched instruction (registered)
- inst_valid  out  1  inst updated by a fetch in the previous cycle

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, write pointer = 0, all per-entry valid bits = 0.
  - ld_ready = 0, load_done = 0, load_err = 0, load_count = 0.
  - inst = HALT_WORD, inst_valid = 0.
  - Memory contents need not be reset; valid bits mask them.
- States: IDLE, LOAD, RUN.
- IDLE:
  - ld_ready = 0; fetches ignored (inst holds, inst_valid = 0).
  - load_start -> LOAD next cycle.
- Entering LOAD (from IDLE or RUN):
  - Same edge: pointer = 0, load_count = 0, all valid bits cleared, load_done = 0, load_err = 0.
- LOAD:
  - ld_ready = 1 (combinational from state).
  - Beat accepted when ld_valid & ld_ready: mem[ptr] = ld_data, valid[ptr] = 1, ptr++, load_count++.
  - Accepted beat with ld_last = 1 -> RUN, load_done = 1.
  - Accepted beat at ptr = DEPTH-1 with ld_last = 0 -> RUN, load_done = 1, load_err = 1. Further words are not accepted (ld_ready = 0 in RUN).
  - load_start during LOAD: restart (pointer/valid/count cleared), current beat discarded.
  - Fetches ignored in LOAD.
- RUN:
  - fetch_en = 1 -> next edge: inst = valid[PC] ? mem[PC] : HALT_WORD, inst_valid = 1.
  - fetch_en = 0 -> inst holds, inst_valid = 0.
  - load_start -> LOAD; if fetch_en is asserted the same cycle, load_start wins, no fetch, inst_valid = 0.
- Latency: fetch 1 cycle; loader 1 word/cycle; first fetch possible the cycle after load_done rises.
- PC wraps naturally within AW bits; no out-of-range case exists.
- load_count saturates at DEPTH (needs AW+1 bits).
- Reset mid-load or mid-run: immediate return to reset values; the program is lost (valid bits cleared).

Test Plan:
- Reset with reset_n low mid-cycle -> inst = 9'h1FF, inst_valid = 0, ld_ready = 0, load_done = 0 asynchronously, before the next CLK edge.
- load_start, then 10 words 9'h000..9'h009 back-to-back, ld_last on the 10th -> load_count = 10, load_done = 1, load_err = 0. Fetch PC = 0..9 returns the words one cycle after each fetch_en. Fetch PC = 10 and PC = 255 -> 9'h1FF.
- Loader with ld_valid toggling every other cycle (gaps) -> only handshaked words stored in order; load_count matches the beat count.
- Reload: in RUN, load 3 words 9'h055, 9'h0AA, 9'h123 -> PC = 3 (written in the first load) now returns 9'h1FF. load_start together with fetch_en -> inst_valid = 0 next cycle.
- Overflow: 256 words without ld_last -> load_err = 1, load_done = 1, load_count = 256. ld_ready = 0 for the 257th word; PC = 255 returns the 256th word.
- Reset asserted after 5 loaded words -> state IDLE. A fetch after a new 1-word load at PC = 2 returns 9'h1FF.
